// File: rtl/cls_pkg.sv
// ---------------------------------------------------------------------------
// cls_pkg
// Shared definitions for the PmodCLS display path.
//   - Arbiter FSM state encoding (IDLE/START/WAIT_END/HOLD/DONE) and the
//     enum type built on it.
//   - CLS_FRAME_W : default display frame width in bits (19 bytes).
//   - ESC_CLR     : "ESC [ j" clear-screen prefix that frame builders place
//                   in the top three bytes of every frame.
// ---------------------------------------------------------------------------
package cls_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] WAIT_END = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = IDLE,
        ST_START    = START,
        ST_WAIT_END = WAIT_END,
        ST_HOLD     = HOLD,
        ST_DONE     = DONE
    } state_t;

    localparam int CLS_FRAME_W = 152;

    localparam logic [23:0] ESC_CLR = 24'h1B5B6A;

endpackage

// File: rtl/cls_display_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin encoder: returns the index of the first set
// request bit at or after ptr_i, wrapping around NREQ.
// Ports:
//   req_i   [NREQ-1:0] request vector
//   ptr_i   [GW-1:0]   round-robin start position (0..NREQ-1)
//   idx_o   [GW-1:0]   selected index (0 when nothing requested)
//   valid_o            at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 3,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   idx_o,
    output logic            valid_o
);

    // cand[k] is the requester examined k-th, counting from the pointer.
    logic [GW-1:0]   cand [NREQ];
    logic [NREQ-1:0] hit;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign cand[gi] = GW'((int'(ptr_i) + gi) % NREQ);
        assign hit[gi]  = req_i[cand[gi]];
    end

    // Scan from the farthest candidate back towards the pointer so the
    // nearest set bit is the last (winning) assignment.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/cls_display_arbiter.sv
// ---------------------------------------------------------------------------
// cls_display_arbiter
// Shares one PmodCLS SPI link between NREQ frame producers. Requesters are
// granted round-robin; the winning frame is latched, a single
// begin_transmission pulse is issued, and after end_transmission the image
// is held HOLD_CYCLES before the requester is acknowledged. If the SPI
// master never reports completion within TIMEOUT_CYCLES the requester gets
// an err pulse instead and the sticky timeout_flag is set.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req [NREQ]         level requests, held until ack/err
//   frame_in           requester i frame at [i*FRAME_W +: FRAME_W]
//   ack/err [NREQ]     one-cycle completion / timeout pulse to the grantee
//   spi_data           latched frame for the SPI byte master
//   spi_begin          one-cycle begin_transmission pulse
//   spi_end            end_transmission from the SPI master
//   slave_select       active-low chip select
//   busy               high from grant through the ack/err cycle
//   grant_id           index of current or last grant
//   timeout_flag       sticky timeout indicator
// ---------------------------------------------------------------------------
module cls_display_arbiter
    import cls_pkg::*;
#(
    parameter int  NREQ           = 3,
    parameter int  FRAME_W        = CLS_FRAME_W,
    parameter int  HOLD_CYCLES    = 125_000_000,
    parameter int  TIMEOUT_CYCLES = 250_000_000,
    parameter int  CNT_W          = 28,
    localparam int GW             = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*FRAME_W-1:0] frame_in,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         err,
    output logic [FRAME_W-1:0]      spi_data,
    output logic                    spi_begin,
    input  logic                    spi_end,
    output logic                    slave_select,
    output logic                    busy,
    output logic [GW-1:0]           grant_id,
    output logic                    timeout_flag
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] spi_data_q, spi_data_d;
    logic               spi_begin_q, spi_begin_d;
    logic               ss_q, ss_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic               busy_q, busy_d;
    logic [GW-1:0]      gid_q, gid_d;
    logic               tflag_q, tflag_d;

    logic [FRAME_W-1:0] frames [NREQ];
    logic [GW-1:0]      pick_idx;
    logic               pick_valid;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_frames
        assign frames[gi] = frame_in[gi*FRAME_W +: FRAME_W];
    end

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            spi_data_q  <= '0;
            spi_begin_q <= 1'b0;
            ss_q        <= 1'b1;
            ack_q       <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            gid_q       <= '0;
            tflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            spi_data_q  <= spi_data_d;
            spi_begin_q <= spi_begin_d;
            ss_q        <= ss_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            gid_q       <= gid_d;
            tflag_q     <= tflag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        spi_data_d  = spi_data_q;
        spi_begin_d = spi_begin_q;
        ss_d        = ss_q;
        ack_d       = ack_q;
        err_d       = err_q;
        busy_d      = busy_q;
        gid_d       = gid_q;
        tflag_d     = tflag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    spi_data_d  = frames[pick_idx];
                    gid_d       = pick_idx;
                    busy_d      = 1'b1;
                    ss_d        = 1'b0;
                    spi_begin_d = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                // spi_end is deliberately not looked at here: a stale
                // completion from the master must not end this transfer.
                spi_begin_d = 1'b0;
                cnt_d       = '0;
                state_d     = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (spi_end) begin
                    ss_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    ss_d          = 1'b1;
                    err_d[gid_q]  = 1'b1;
                    tflag_d       = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    ack_d[gid_q] = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                ack_d   = '0;
                err_d   = '0;
                busy_d  = 1'b0;
                // Next search starts just past the requester just served.
                ptr_d   = (gid_q == GW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign spi_data     = spi_data_q;
    assign spi_begin    = spi_begin_q;
    assign slave_select = ss_q;
    assign ack          = ack_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign grant_id     = gid_q;
    assign timeout_flag = tflag_q;

endmodule
